// File: rtl/ps2_mouse_packet_ctrl.sv
// ps2_mouse_packet_ctrl: pops bytes from the PS/2 receiver FIFO, aligns them
// into mouse packets (header bit 3 must be set), decodes buttons and signed
// deltas, and keeps a cursor position clamped to the screen.
// Optional build macro: MOUSE_WHEEL_EN adds a 4th (IntelliMouse) byte, the
// S_B3 state, a 3-bit state code and the signed wheel[3:0] output.
module ps2_mouse_packet_ctrl #(
  parameter int unsigned SCR_W       = 640,
  parameter int unsigned SCR_H       = 480,
  parameter int unsigned INIT_X      = 320,
  parameter int unsigned INIT_Y      = 240,
  parameter int unsigned SHIFT       = 1,
  parameter int unsigned TIMEOUT_CYC = 2500000
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [7:0] byte_data,
  input  logic       byte_ready,
  input  logic       byte_overflow,
  output logic       byte_rdn,
  output logic       pkt_valid,
  output logic [2:0] btn,
  output logic [8:0] dx,
  output logic [8:0] dy,
  output logic [9:0] posx,
  output logic [8:0] posy,
  output logic       left_press,
  output logic [7:0] sync_err,
`ifdef MOUSE_WHEEL_EN
  output logic [3:0] wheel,
  output logic [2:0] state
`else
  output logic [1:0] state
`endif
);

  localparam int unsigned CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic signed [10:0] X_MAX = 11'(SCR_W - 1);
  localparam logic signed [10:0] Y_MAX = 11'(SCR_H - 1);

`ifdef MOUSE_WHEEL_EN
  typedef enum logic [2:0] {
    S_B0 = 3'd0, S_B1 = 3'd1, S_B2 = 3'd2, S_B3 = 3'd3, S_UPD = 3'd4
  } state_e;
`else
  typedef enum logic [1:0] {
    S_B0 = 2'd0, S_B1 = 2'd1, S_B2 = 2'd2, S_UPD = 2'd3
  } state_e;
`endif

  state_e             state_q, state_d;
  logic               hold_q, hold_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [1:0]         hdr_ovf_q, hdr_ovf_d;     // {y, x} overflow flags
  logic [1:0]         hdr_sign_q, hdr_sign_d;   // {y, x} delta sign bits
  logic [2:0]         hdr_btn_q, hdr_btn_d;
  logic [7:0]         b1_q, b1_d;
`ifdef MOUSE_WHEEL_EN
  logic [7:0]         b2_q, b2_d;
  logic [3:0]         wheel_q, wheel_d;
`endif
  logic               pkt_valid_q, pkt_valid_d;
  logic [2:0]         btn_q, btn_d;
  logic [8:0]         dx_q, dx_d;
  logic [8:0]         dy_q, dy_d;
  logic [9:0]         posx_q, posx_d;
  logic [8:0]         posy_q, posy_d;
  logic               left_press_q, left_press_d;
  logic [7:0]         sync_err_q, sync_err_d;

  logic               in_rx, in_mid, pop, tmo, err_inc, do_upd;
  logic [7:0]         b2_v;
  logic [8:0]         dx_eff, dy_eff;
  logic signed [8:0]  dx_sh, dy_sh;
  logic signed [10:0] nx, ny;
  logic [9:0]         nx_clamp;
  logic [8:0]         ny_clamp;

  // Pop qualification: receiving state, data present, not in hold-off, no overflow
  always_comb begin
    in_rx  = 1'b0;
    in_mid = 1'b0;
`ifdef MOUSE_WHEEL_EN
    in_rx  = state_q inside {S_B0, S_B1, S_B2, S_B3};
    in_mid = state_q inside {S_B1, S_B2, S_B3};
`else
    in_rx  = state_q inside {S_B0, S_B1, S_B2};
    in_mid = state_q inside {S_B1, S_B2};
`endif
    pop = rstn && in_rx && byte_ready && !hold_q && !byte_overflow;
    tmo = in_mid && !pop && (cnt_q == CNT_LAST);
  end

  // Delta decode and clamped cursor update from the packet being completed
  always_comb begin
`ifdef MOUSE_WHEEL_EN
    b2_v = b2_q;
`else
    b2_v = byte_data;
`endif
    dx_eff = hdr_ovf_q[0] ? 9'd0 : {hdr_sign_q[0], b1_q};
    dy_eff = hdr_ovf_q[1] ? 9'd0 : {hdr_sign_q[1], b2_v};
    dx_sh  = $signed(dx_eff) >>> SHIFT;
    dy_sh  = $signed(dy_eff) >>> SHIFT;
    nx     = $signed({1'b0, posx_q}) + 11'(dx_sh);
    ny     = $signed({2'b00, posy_q}) - 11'(dy_sh);
    if (nx[10])         nx_clamp = 10'd0;
    else if (nx > X_MAX) nx_clamp = 10'(X_MAX);
    else                nx_clamp = 10'(nx);
    if (ny[10])         ny_clamp = 9'd0;
    else if (ny > Y_MAX) ny_clamp = 9'(Y_MAX);
    else                ny_clamp = 9'(ny);
  end

  // Next-state, pop strobe and registered-output next values
  always_comb begin
    state_d      = state_q;
    hold_d       = pop;
    cnt_d        = '0;
    hdr_ovf_d    = hdr_ovf_q;
    hdr_sign_d   = hdr_sign_q;
    hdr_btn_d    = hdr_btn_q;
    b1_d         = b1_q;
`ifdef MOUSE_WHEEL_EN
    b2_d         = b2_q;
    wheel_d      = wheel_q;
`endif
    pkt_valid_d  = 1'b0;
    left_press_d = 1'b0;
    btn_d        = btn_q;
    dx_d         = dx_q;
    dy_d         = dy_q;
    posx_d       = posx_q;
    posy_d       = posy_q;
    sync_err_d   = sync_err_q;
    err_inc      = 1'b0;
    do_upd       = 1'b0;
    byte_rdn     = !pop;

    if (in_mid && !pop) cnt_d = cnt_q + CNT_W'(1);

    if (byte_overflow) begin
      state_d = S_B0;
      err_inc = in_mid;
    end else if (tmo) begin
      state_d = S_B0;
      err_inc = 1'b1;
    end else begin
      case (state_q)
        S_B0: if (pop) begin
          if (byte_data[3]) begin
            hdr_ovf_d  = byte_data[7:6];
            hdr_sign_d = byte_data[5:4];
            hdr_btn_d  = byte_data[2:0];
            state_d    = S_B1;
          end else begin
            err_inc = 1'b1;
          end
        end
        S_B1: if (pop) begin
          b1_d    = byte_data;
          state_d = S_B2;
        end
`ifdef MOUSE_WHEEL_EN
        S_B2: if (pop) begin
          b2_d    = byte_data;
          state_d = S_B3;
        end
        S_B3: if (pop) begin
          do_upd  = 1'b1;
          state_d = S_UPD;
        end
`else
        S_B2: if (pop) begin
          do_upd  = 1'b1;
          state_d = S_UPD;
        end
`endif
        default: state_d = S_B0;
      endcase
    end

    if (do_upd) begin
      pkt_valid_d  = 1'b1;
      btn_d        = hdr_btn_q;
      left_press_d = hdr_btn_q[0] & ~btn_q[0];
      dx_d         = dx_eff;
      dy_d         = dy_eff;
      posx_d       = nx_clamp;
      posy_d       = ny_clamp;
`ifdef MOUSE_WHEEL_EN
      wheel_d      = byte_data[3:0];
`endif
    end

    if (err_inc && (sync_err_q != 8'hFF)) sync_err_d = sync_err_q + 8'd1;
  end

  // State and output registers, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q      <= S_B0;
      hold_q       <= 1'b0;
      cnt_q        <= '0;
      hdr_ovf_q    <= 2'd0;
      hdr_sign_q   <= 2'd0;
      hdr_btn_q    <= 3'd0;
      b1_q         <= 8'd0;
`ifdef MOUSE_WHEEL_EN
      b2_q         <= 8'd0;
      wheel_q      <= 4'd0;
`endif
      pkt_valid_q  <= 1'b0;
      btn_q        <= 3'd0;
      dx_q         <= 9'd0;
      dy_q         <= 9'd0;
      posx_q       <= 10'(INIT_X);
      posy_q       <= 9'(INIT_Y);
      left_press_q <= 1'b0;
      sync_err_q   <= 8'd0;
    end else begin
      state_q      <= state_d;
      hold_q       <= hold_d;
      cnt_q        <= cnt_d;
      hdr_ovf_q    <= hdr_ovf_d;
      hdr_sign_q   <= hdr_sign_d;
      hdr_btn_q    <= hdr_btn_d;
      b1_q         <= b1_d;
`ifdef MOUSE_WHEEL_EN
      b2_q         <= b2_d;
      wheel_q      <= wheel_d;
`endif
      pkt_valid_q  <= pkt_valid_d;
      btn_q        <= btn_d;
      dx_q         <= dx_d;
      dy_q         <= dy_d;
      posx_q       <= posx_d;
      posy_q       <= posy_d;
      left_press_q <= left_press_d;
      sync_err_q   <= sync_err_d;
    end
  end

  assign pkt_valid  = pkt_valid_q;
  assign btn        = btn_q;
  assign dx         = dx_q;
  assign dy         = dy_q;
  assign posx       = posx_q;
  assign posy       = posy_q;
  assign left_press = left_press_q;
  assign sync_err   = sync_err_q;
  assign state      = state_q;
`ifdef MOUSE_WHEEL_EN
  assign wheel      = wheel_q;
`endif

endmodule

// File: tb/tb_ps2_mouse_packet_ctrl.sv
// Bench for ps2_mouse_packet_ctrl: a byte FIFO stands in for the receiver,
// a packet-level model predicts every output each cycle, and directed
// packets pin the model with literal expectations.
module tb_ps2_mouse_packet_ctrl;

  localparam int TO = 40;
  localparam int SH = 1;

  logic       clk;
  logic       rstn;
  logic [7:0] byte_data;
  logic       byte_ready;
  logic       byte_overflow;
  logic       byte_rdn;
  logic       pkt_valid;
  logic [2:0] btn;
  logic [8:0] dx;
  logic [8:0] dy;
  logic [9:0] posx;
  logic [8:0] posy;
  logic       left_press;
  logic [7:0] sync_err;
  logic [1:0] state;

  ps2_mouse_packet_ctrl #(
    .SCR_W(640), .SCR_H(480), .INIT_X(320), .INIT_Y(240),
    .SHIFT(SH), .TIMEOUT_CYC(TO)
  ) dut (
    .clk(clk), .rstn(rstn), .byte_data(byte_data), .byte_ready(byte_ready),
    .byte_overflow(byte_overflow), .byte_rdn(byte_rdn), .pkt_valid(pkt_valid),
    .btn(btn), .dx(dx), .dy(dy), .posx(posx), .posy(posy),
    .left_press(left_press), .sync_err(sync_err), .state(state)
  );

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 0;
  bit ready_gate = 1;
  logic [7:0] fifo[$];

  // packet-level model
  logic [7:0] m_b[3];
  int   m_n = 0;
  bit   m_upd = 0, m_lastpop = 0, m_pop, m_mid, m_tmo, m_errf;
  int   m_idle = 0;
  bit   m_valid = 0, m_lp = 0;
  logic [2:0] m_btn = 0;
  logic [8:0] m_dx = 0, m_dy = 0;
  int   m_x = 320, m_y = 240, m_err = 0;
  int   dxv, dyv;
  logic [7:0] hdr;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Receiver FIFO front: head byte and non-empty flag, refreshed after each edge
  initial begin
    byte_ready = 1'b0;
    byte_data  = 8'h00;
    forever begin
      @(posedge clk);
      #1;
      if (fifo.size() != 0 && ready_gate) begin
        byte_ready = 1'b1;
        byte_data  = fifo[0];
      end else begin
        byte_ready = 1'b0;
        byte_data  = 8'($urandom);
      end
    end
  end

  // Per-cycle compare against the model, then advance model and FIFO
  always @(negedge clk) begin
    m_mid = (m_n > 0) && !m_upd;
    m_pop = (rstn === 1'b1) && !m_upd && byte_ready && !m_lastpop && !byte_overflow;
    m_tmo = m_mid && !m_pop && (m_idle == TO - 1);
    if (chk_en) begin
      chk("cyc byte_rdn", byte_rdn, !m_pop);
      chk("cyc pkt_valid", pkt_valid, m_valid);
      chk("cyc btn", btn, m_btn);
      chk("cyc dx", dx, m_dx);
      chk("cyc dy", dy, m_dy);
      chk("cyc posx", posx, m_x);
      chk("cyc posy", posy, m_y);
      chk("cyc left_press", left_press, m_lp);
      chk("cyc sync_err", sync_err, m_err);
      chk("cyc state", state, m_upd ? 3 : m_n);
    end
    if (rstn !== 1'b1) begin
      m_n = 0; m_upd = 0; m_lastpop = 0; m_idle = 0; m_valid = 0; m_lp = 0;
      m_btn = 0; m_dx = 0; m_dy = 0; m_x = 320; m_y = 240; m_err = 0;
    end else begin
      m_valid = 0;
      m_lp    = 0;
      m_errf  = 0;
      if (byte_overflow) begin
        m_errf = m_mid; m_n = 0; m_upd = 0;
      end else if (m_tmo) begin
        m_errf = 1; m_n = 0;
      end else if (m_upd) begin
        m_upd = 0; m_n = 0;
      end else if (m_pop) begin
        if (m_n == 0 && !byte_data[3]) m_errf = 1;
        else begin
          m_b[m_n] = byte_data;
          m_n++;
          if (m_n == 3) begin
            hdr = m_b[0];
            dxv = hdr[6] ? 0 : int'(m_b[1]) - (hdr[4] ? 256 : 0);
            dyv = hdr[7] ? 0 : int'(m_b[2]) - (hdr[5] ? 256 : 0);
            m_x = m_x + (dxv >>> SH);
            m_y = m_y - (dyv >>> SH);
            if (m_x < 0) m_x = 0;
            if (m_x > 639) m_x = 639;
            if (m_y < 0) m_y = 0;
            if (m_y > 479) m_y = 479;
            m_dx = 9'(dxv);
            m_dy = 9'(dyv);
            m_lp = hdr[0] & ~m_btn[0];
            m_btn = hdr[2:0];
            m_valid = 1;
            m_upd = 1;
          end
        end
      end
      m_idle = (m_pop || !m_mid || byte_overflow || m_tmo) ? 0 : m_idle + 1;
      m_lastpop = m_pop;
      if (m_errf && m_err < 255) m_err++;
      if (byte_rdn === 1'b0 && fifo.size() != 0) void'(fifo.pop_front());
    end
  end

  task automatic do_reset();
    @(posedge clk); #2;
    rstn = 1'b0; byte_overflow = 1'b0; ready_gate = 1'b1; fifo.delete();
    repeat (2) @(posedge clk);
    #2 rstn = 1'b1;
  endtask

  task automatic wait_valid(input string nm);
    bit got = 0;
    for (int k = 0; k < 200 && !got; k++) begin
      @(negedge clk);
      if (pkt_valid === 1'b1) got = 1;
    end
    chk({nm, " pkt_valid seen"}, got, 1);
  endtask

  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                      input string nm);
    fifo.push_back(a); fifo.push_back(b); fifo.push_back(c);
    wait_valid(nm);
  endtask

  initial begin
    int exp_x[6] = '{383, 446, 509, 572, 635, 639};
    bit drained;
    int r;
    logic [7:0] rb;
    rstn = 1'b0;
    byte_overflow = 1'b0;
    repeat (2) @(posedge clk);
    #2 chk_en = 1;
    @(negedge clk);
    chk("rst posx", posx, 320);
    chk("rst posy", posy, 240);
    chk("rst state", state, 0);
    chk("rst byte_rdn", byte_rdn, 1);
    chk("rst sync_err", sync_err, 0);
    @(posedge clk); #2 rstn = 1'b1;

    send(8'h08, 8'h05, 8'h03, "t1");
    chk("t1 dx", dx, 5);
    chk("t1 dy", dy, 3);
    chk("t1 posx", posx, 322);
    chk("t1 posy", posy, 239);
    chk("t1 btn", btn, 0);

    do_reset();
    send(8'h18, 8'hFB, 8'h00, "t2");
    chk("t2 dx", dx, 9'h1FB);
    chk("t2 posx", posx, 317);
    chk("t2 posy", posy, 240);

    do_reset();
    fifo.push_back(8'h05);
    send(8'h08, 8'h00, 8'h00, "t3");
    chk("t3 sync_err", sync_err, 1);
    chk("t3 posx", posx, 320);

    do_reset();
    fifo.push_back(8'h08);
    repeat (TO + 5) @(negedge clk);
    chk("t4 state", state, 0);
    chk("t4 sync_err", sync_err, 1);
    send(8'h08, 8'h02, 8'h00, "t4");
    chk("t4 posx", posx, 321);

    do_reset();
    for (int i = 0; i < 6; i++) begin
      send(8'h08, 8'h7F, 8'h00, "t5");
      chk("t5 posx", posx, exp_x[i]);
    end
    send(8'h48, 8'h7F, 8'h00, "t5 xovf");
    chk("t5 xovf posx", posx, 639);

    do_reset();
    send(8'h09, 8'h00, 8'h00, "t6a");
    chk("t6a left_press", left_press, 1);
    chk("t6a btn", btn, 1);
    send(8'h09, 8'h00, 8'h00, "t6b");
    chk("t6b left_press", left_press, 0);
    send(8'h08, 8'h00, 8'h00, "t6c");
    chk("t6c btn", btn, 0);
    send(8'h08, 8'h20, 8'h20, "t6d");
    chk("t6d posx", posx, 336);
    chk("t6d posy", posy, 224);
    fifo.push_back(8'h00); fifo.push_back(8'h08); fifo.push_back(8'h10);
    repeat (10) @(negedge clk);
    chk("t6 mid state", state, 2);
    @(posedge clk); #2 rstn = 1'b0;
    @(posedge clk); #2 rstn = 1'b1;
    @(negedge clk);
    chk("t6 rst state", state, 0);
    chk("t6 rst posx", posx, 320);
    chk("t6 rst posy", posy, 240);
    chk("t6 rst sync_err", sync_err, 0);
    chk("t6 rst btn", btn, 0);
    chk("t6 rst dx", dx, 0);

    do_reset();
    for (int i = 0; i < 260; i++) fifo.push_back(8'h00);
    drained = 0;
    for (int k = 0; k < 1000 && !drained; k++) begin
      @(negedge clk);
      if (fifo.size() == 0) drained = 1;
    end
    chk("sat drained", drained, 1);
    repeat (3) @(negedge clk);
    chk("sat sync_err", sync_err, 255);

    do_reset();
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #2;
      r = int'($urandom_range(0, 99));
      ready_gate = ($urandom_range(0, 9) != 0);
      byte_overflow = (r >= 98);
      if (r < 35 && fifo.size() < 8) begin
        rb = 8'($urandom);
        if ($urandom_range(0, 3) != 0) rb[3] = 1'b1;
        if ($urandom_range(0, 3) != 0) rb[7:6] = 2'b00;
        fifo.push_back(rb);
      end
      if (r == 97) begin
        ready_gate = 1'b0;
        repeat (TO + 3) @(posedge clk);
        #2 ready_gate = 1'b1;
      end
    end
    @(posedge clk); #2;
    byte_overflow = 1'b0;
    ready_gate = 1'b1;
    repeat (40) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    n_fail++;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
